load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage and the word-addressed RAM controller. Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM-controller transactions.
- The RAM controller has no byte enables, so sub-word stores use read-modify-write.
- Only one request is outstanding at a time. Sign/zero extension, alignment checks and range checks happen here.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit RAM words; legal word index is 0..DEPTH_WORDS-1.
- XLEN, 32, data and address width.

Ports:
- clk  in  1  system clock; RAM controller clk1 and clk2 are tied to it.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (size and sign).
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  misaligned, out-of-range or illegal funct3; qualified by resp_valid.
- resp_rdata  out  XLEN  extended load result; 0 for stores and errors.
- ram_addr_out  out  XLEN  word index to RAM ADDR_OUT (registered).
- ram_data  in  XLEN  RAM DATA.
- ram_addr_in  out  XLEN  word index to RAM ADDR_IN (registered).
- ram_value  out  XLEN  RAM VALUE (registered).
- ram_wd  out  1  RAM WD (registered).

Behaviour:
- Reset values: req_ready=1 once in IDLE; resp_valid=0, resp_err=0, resp_rdata=0, ram_addr_out=0, ram_addr_in=0, ram_value=0, ram_wd=0; state=IDLE.
- Accept: req_valid&&req_ready at edge E0 latches the op, addr[1:0] and word index addr>>2.
- Error check at accept. Any of these is an error:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - Word index >= DEPTH_WORDS.
  - Load funct3 in {011,110,111}.
  - Store funct3 > 010.
- On error: go to DONE, no RAM access, resp_err=1, resp_rdata=0.
- RAM read timing: ram_addr_out is set at E0. RAM registers the address at E1 and updates DATA at E2; the block samples ram_data at E3. ram_addr_out is held from E0 until the next accept.
- Load path: IDLE -> RD1 -> RD2 -> RD3 -> DONE.
  - At E3, select the byte/half by the latched addr[1:0] and extend: LB/LH sign-extend, LBU/LHU zero-extend.
  - resp_valid is high in the cycle after E3, giving 4-cycle latency.
- SW path: IDLE -> WR -> DONE.
  - At E0: ram_addr_in=index, ram_value=wdata, ram_wd=1.
  - RAM writes at E1; ram_wd drops at E1; resp_valid in the cycle after E1.
- SB/SH path: IDLE -> RD1 -> RD2 -> RD3 -> WR -> DONE.
  - At E3, merge wdata[7:0] or [15:0] into the sampled word at lane addr[1:0] and issue the write.
  - RAM writes at E4; resp_valid in the cycle after E4.
- DONE: resp_valid=1 for exactly one cycle, then IDLE.
  - req_ready is 0 in every state except IDLE, so back-to-back requests are spaced by DONE.
  - A load issued after a store always observes the stored data.
- resp_rdata and resp_err hold their values until the next DONE.
- Reset mid-operation:
  - A write whose ram_wd=1 is visible at the reset edge completes, because RAM samples WD on the same edge.
  - No further RAM write is issued after reset.
  - The request in flight is dropped with no response.
- req_* inputs are ignored outside the accept edge.

Optional Feature:
- Macro LSU_FWD_EN adds a last-write buffer: valid bit, word index and full merged word.
- The buffer is updated on every RAM write and cleared by reset.
- With LSU_FWD_EN defined:
  - A load whose index matches a valid buffer entry skips RAM: IDLE -> DONE, resp_valid in the cycle after E0.
  - A matching SB/SH merges into the buffer word and goes IDLE -> WR -> DONE.
- Without LSU_FWD_EN, all accesses take the RAM paths above and latencies are fixed.

Decomposition:
- Shared package lsu_pkg holds:
  - the funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - the state enum (IDLE, RD1, RD2, RD3, WR, DONE).
- One sub-module, lsu_lane_align, is purely combinational and does two things:
  - load extract/extend from (word, addr[1:0], funct3);
  - store merge from (old word, wdata, addr[1:0], funct3).

Test Plan:
1. SW addr 0x10, data 0xDEADBEEF, then LW 0x10: ram_wd=1 for one cycle with ram_addr_in=4; store resp_valid 2 cycles after accept; load resp_valid 4 cycles after accept with rdata=0xDEADBEEF, resp_err=0.
2. After 1, LB 0x13: rdata=0xFFFFFFDE. LBU 0x13: rdata=0x000000DE. LH 0x12: rdata=0xFFFFDEAD. LHU 0x10: rdata=0x0000BEEF.
3. After 1, SB 0x11 data 0x55: RAM word 4 becomes 0xDEAD55EF; resp_valid 5 cycles after accept; the following LW 0x10 returns 0xDEAD55EF.
4. Errors:
   - LW 0x02: resp_err=1, rdata=0, ram_wd never asserted, resp_valid in the cycle after accept.
   - SH 0x01: same response as LW 0x02.
   - LW 0x200 (index 128): resp_err=1.
   - funct3=011 load: resp_err=1.
5. Assert rst_n=0 during RD2 of a load: next cycle state=IDLE, req_ready=1, resp_valid=0; no response is ever produced for that load.
6. With LSU_FWD_EN: SW 0x20 data 0x12345678, then LW 0x20: resp_valid in the cycle after accept, rdata=0x12345678. Without LSU_FWD_EN the same LW takes 4 cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings and FSM states.
`timescale 1ns/1ps
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, RD1, RD2, RD3, WR, DONE} lsu_state_e;
endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: load extract+extend and store merge into an old word.
`timescale 1ns/1ps
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_data,
  output logic [XLEN-1:0] st_word
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    ld_data = {{(XLEN-8){b[7]}}, b};
      F3_BU:   ld_data = {{(XLEN-8){1'b0}}, b};
      F3_H:    ld_data = {{(XLEN-16){h[15]}}, h};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}}, h};
      default: ld_data = word;
    endcase
  end

  always_comb begin
    st_word = word;
    case (funct3)
      F3_B:    st_word[{off, 3'b000} +: 8]    = wdata[7:0];
      F3_H:    st_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: st_word = wdata;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// RISC-V load/store front end for a word RAM without byte enables (sub-word stores RMW).
// Optional LSU_FWD_EN: last-write buffer serving matching loads and sub-word merges.
`timescale 1ns/1ps
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic            resp_err,
  output logic [XLEN-1:0] resp_rdata,
  output logic [XLEN-1:0] ram_addr_out,
  input  logic [XLEN-1:0] ram_data,
  output logic [XLEN-1:0] ram_addr_in,
  output logic [XLEN-1:0] ram_value,
  output logic            ram_wd
);
  lsu_state_e      state, state_nxt;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [XLEN-1:0] idx_q, wdata_q;
  logic [XLEN-1:0] req_idx, wr_idx;
  logic            acc, req_err, fwd_hit, wr_issue;
  logic [XLEN-1:0] al_word, al_wdata, ld_data, st_word;
  logic [1:0]      al_off;
  logic [2:0]      al_f3;

  assign req_idx    = {2'b00, req_addr[XLEN-1:2]};
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign acc        = req_valid && (state == IDLE);

  always_comb begin
    req_err = req_we ? (req_funct3 > F3_W) : (req_funct3 inside {3'b011, 3'b110, 3'b111});
    if (req_funct3[1:0] == 2'b01 && req_addr[0])          req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_idx >= XLEN'(DEPTH_WORDS))                    req_err = 1'b1;
  end

`ifdef LSU_FWD_EN
  logic            fwd_vld;
  logic [XLEN-1:0] fwd_idx, fwd_word;
  assign fwd_hit = fwd_vld && (fwd_idx == req_idx);
  // In IDLE the lane logic works on the buffered word; otherwise on RAM data.
  assign al_word = (state == IDLE) ? fwd_word : ram_data;
`else
  assign fwd_hit = 1'b0;
  assign al_word = ram_data;
`endif

  assign al_off   = (state == IDLE) ? req_addr[1:0] : off_q;
  assign al_f3    = (state == IDLE) ? req_funct3    : f3_q;
  assign al_wdata = (state == IDLE) ? req_wdata     : wdata_q;
  assign wr_idx   = (state == IDLE) ? req_idx       : idx_q;

  // SW (and buffered sub-word stores) write straight from IDLE; RMW writes from RD3.
  assign wr_issue = (acc && !req_err && req_we && (req_funct3 == F3_W || fwd_hit)) ||
                    (state == RD3 && we_q);

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .word    (al_word),
    .off     (al_off),
    .funct3  (al_f3),
    .wdata   (al_wdata),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) begin
        if (req_err || (!req_we && fwd_hit))                  state_nxt = DONE;
        else if (req_we && (req_funct3 == F3_W || fwd_hit))   state_nxt = WR;
        else                                                  state_nxt = RD1;
      end
      RD1:     state_nxt = RD2;
      RD2:     state_nxt = RD3;
      RD3:     state_nxt = we_q ? WR : DONE;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
      idx_q        <= '0;
      wdata_q      <= '0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      ram_addr_out <= '0;
      ram_addr_in  <= '0;
      ram_value    <= '0;
      ram_wd       <= 1'b0;
    end else begin
      ram_wd <= wr_issue;
      if (wr_issue) begin
        ram_addr_in <= wr_idx;
        ram_value   <= st_word;
      end
      case (state)
        IDLE: if (acc) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          off_q   <= req_addr[1:0];
          idx_q   <= req_idx;
          wdata_q <= req_wdata;
          if (req_err) begin
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            ram_addr_out <= req_idx;
            if (!req_we && fwd_hit) begin
              resp_err   <= 1'b0;
              resp_rdata <= ld_data;
            end
          end
        end
        RD3: if (!we_q) begin
          resp_err   <= 1'b0;
          resp_rdata <= ld_data;
        end
        WR: begin
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_FWD_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_vld  <= 1'b0;
      fwd_idx  <= '0;
      fwd_word <= '0;
    end else if (wr_issue) begin
      fwd_vld  <= 1'b1;
      fwd_idx  <= wr_idx;
      fwd_word <= st_word;
    end
  end
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word RAM model with 2-cycle read, byte-array reference model.
`timescale 1ns/1ps
module tb_load_store_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 128;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready, req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic            resp_valid, resp_err;
  logic [XLEN-1:0] resp_rdata, ram_addr_out, ram_data, ram_addr_in, ram_value;
  logic            ram_wd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH_WORDS(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .ram_addr_out (ram_addr_out),
    .ram_data     (ram_data),
    .ram_addr_in  (ram_addr_in),
    .ram_value    (ram_value),
    .ram_wd       (ram_wd)
  );

  // RAM controller: address registered at one edge, data updated at the next.
  logic [31:0] mem [0:DEPTH-1];
  logic [6:0]  raddr_q;
  bit          mem_clr;
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (ram_wd) mem[ram_addr_in[6:0]] <= ram_value;
    raddr_q  <= ram_addr_out[6:0];
    ram_data <= mem[raddr_q];
  end

  // Reference model: byte-addressed memory plus last-write tracking.
  logic [7:0] ref_b [0:4*DEPTH-1];
  bit         fwd_v;
  int         fwd_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_word(input int i);
    return {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
  endfunction

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    int idx, sz, lat, n, wcnt;
    bit err, hit;
    logic [31:0] exp_rd, exp_word, wa, wv;
    logic [7:0]  bv;
    logic [15:0] hv;
    idx = int'(addr[31:2]);
    sz  = int'(f3[1:0]);
    err = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (sz == 1 && addr[0])          err = 1'b1;
    if (sz == 2 && addr[1:0] != 2'd0) err = 1'b1;
    if (idx >= DEPTH)                err = 1'b1;
    hit = 1'b0;
`ifdef LSU_FWD_EN
    hit = fwd_v && (fwd_i == idx);
`endif
    exp_rd = '0; exp_word = '0;
    if (err) lat = 1;
    else if (!we) begin
      lat = hit ? 1 : 4;
      bv  = ref_b[addr];
      hv  = (sz == 1) ? {ref_b[addr+1], ref_b[addr]} : 16'h0;
      case (f3)
        3'd0:    exp_rd = 32'(signed'(bv));
        3'd4:    exp_rd = {24'h0, bv};
        3'd1:    exp_rd = 32'(signed'(hv));
        3'd5:    exp_rd = {16'h0, hv};
        default: exp_rd = rd_word(idx);
      endcase
    end else begin
      lat = (f3 == 3'd2) ? 2 : (hit ? 2 : 5);
      for (int k = 0; k < (1 << sz); k++) ref_b[addr+k] = wd[8*k +: 8];
      exp_word = rd_word(idx);
      fwd_v = 1'b1;
      fwd_i = idx;
    end

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    chk("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // Garbage request while busy must be ignored.
    req_valid = 1'b1; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    n = 1; wcnt = 0; wa = '0; wv = '0;
    while (!resp_valid && n < 12) begin
      if (ram_wd) begin wcnt++; wa = ram_addr_in; wv = ram_value; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      n++;
    end
    if (ram_wd) wcnt++;
    chk("latency", 32'(n), 32'(lat));
    chk("resp_err", 32'(resp_err), 32'(err));
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("wd_count", 32'(wcnt), (we && !err) ? 32'd1 : 32'd0);
    if (we && !err) begin
      chk("wr_addr", wa, 32'(idx));
      chk("wr_value", wv, exp_word);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  task automatic reset_mid_load();
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h24; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);           // now in RD2
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    fwd_v = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("rst_no_resp", 32'(seen), 32'd0);
  endtask

  initial begin
    bit we;
    logic [2:0] f3;
    logic [31:0] addr;
    rst_n = 1'b0; mem_clr = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;
    fwd_v = 1'b0; fwd_i = 0;
    for (int i = 0; i < 4*DEPTH; i++) ref_b[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; mem_clr = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_ram_wd", 32'(ram_wd), 32'd0);
    chk("rst_ram_addr_out", ram_addr_out, 32'd0);
    chk("rst_ram_addr_in", ram_addr_in, 32'd0);
    chk("rst_ram_value", ram_value, 32'd0);

    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 3'd2, 32'h10, 32'h0);
    do_req(1'b0, 3'd0, 32'h13, 32'h0);
    do_req(1'b0, 3'd4, 32'h13, 32'h0);
    do_req(1'b0, 3'd1, 32'h12, 32'h0);
    do_req(1'b0, 3'd5, 32'h10, 32'h0);
    do_req(1'b1, 3'd0, 32'h11, 32'h55);
    do_req(1'b0, 3'd2, 32'h10, 32'h0);
    chk("sb_word", rd_word(4), 32'hDEAD55EF);
    do_req(1'b0, 3'd2, 32'h02, 32'h0);
    do_req(1'b1, 3'd1, 32'h01, 32'h1234);
    do_req(1'b0, 3'd2, 32'h200, 32'h0);
    do_req(1'b0, 3'd2, 32'h1FC, 32'h0);
    do_req(1'b0, 3'd3, 32'h00, 32'h0);
    do_req(1'b1, 3'd2, 32'h20, 32'h12345678);
    do_req(1'b0, 3'd2, 32'h20, 32'h0);
    reset_mid_load();

    repeat (300) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      if ($urandom_range(3) != 0) begin
        if (we) f3 = 3'($urandom_range(2));
        else case ($urandom_range(4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end
      addr = 32'($urandom_range(63));
      case ($urandom_range(15))
        0: addr = 32'h200 + 32'($urandom_range(63));
        1: addr = 32'h1FC + 32'($urandom_range(3));
        default: ;
      endcase
      do_req(we, f3, addr, $urandom);
    end

    for (int i = 0; i < 16; i++) chk("ram_image", mem[i], rd_word(i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
